// File: rtl/mp_calc_pkg.sv
// Shared encodings for the word-serial multi-precision arithmetic unit:
// operation codes, compare codes and the sequencer state type.
package mp_calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_CMP     = 2'b10,
    OP_ABSDIFF = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_GT   = 2'b01,
    CMP_LT   = 2'b10,
    CMP_EQ   = 2'b11
  } cmp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SWAP = 2'b10,
    HOLD = 2'b11
  } state_e;

  // A borrow out of A + ~B + 1 means A < B; otherwise any nonzero difference means A > B.
  function automatic cmp_e cmp_code(input logic borrow, input logic nonzero);
    if (borrow)       return CMP_LT;
    else if (nonzero) return CMP_GT;
    else              return CMP_EQ;
  endfunction

endpackage

// File: rtl/mp_word_adder.sv
// Combinational W-bit adder slice with carry in and carry out; the arithmetic
// unit iterates this single slice over the operand words.
module mp_word_adder #(
  parameter int W = 128
) (
  input  logic [W-1:0] iA,
  input  logic [W-1:0] iB,
  input  logic         iC,
  output logic [W-1:0] oSum,
  output logic         oC
);

  assign {oC, oSum} = {1'b0, iA} + {1'b0, iB} + {{W{1'b0}}, iC};

endmodule

// File: rtl/mp_arith_unit.sv
// Word-serial ADD/SUB/CMP/ABSDIFF unit: one ADDER_WIDTH-bit adder iterated over
// N_ITER words, with valid/ready handshakes on the operand and result sides.
module mp_arith_unit
  import mp_calc_pkg::*;
#(
  parameter int OPERAND_WIDTH = 512,
  parameter int ADDER_WIDTH   = 128,
  parameter int N_ITER        = OPERAND_WIDTH / ADDER_WIDTH
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [1:0]               iOp,
  input  logic [OPERAND_WIDTH-1:0] iOpA,
  input  logic [OPERAND_WIDTH-1:0] iOpB,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [OPERAND_WIDTH:0]   oRes,
  output logic [1:0]               oCmp
);

  localparam int OW = OPERAND_WIDTH;
  localparam int AW = ADDER_WIDTH;
  localparam int CW = $clog2(N_ITER + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(N_ITER - 1);

  state_e          r_state;
  state_e          w_next_state;
  op_e             r_op;
  logic [OW-1:0]   r_sha;
  logic [OW-1:0]   r_shb;
  logic [OW-1:0]   r_a;
  logic [OW-1:0]   r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_nz;
  logic            r_second;
  logic            r_valid;
  logic [OW:0]     r_res;
  cmp_e            r_cmp;

  logic            w_invert;
  logic [AW-1:0]   w_add_b;
  logic            w_cin;
  logic [AW-1:0]   w_sum;
  logic            w_cout;
  logic [OW-1:0]   w_acc_next;
  logic            w_nz_next;
  logic            w_last;
  logic            w_accept;
  logic            w_fin;
  logic [OW:0]     w_res_fin;
  cmp_e            w_cmp_fin;

  // Subtraction-style ops compute A + ~B + 1; the +1 enters as carry-in of word 0.
  assign w_invert  = (r_op != OP_ADD);
  assign w_add_b   = r_b[AW-1:0] ^ {AW{w_invert}};
  assign w_cin     = (r_cnt == '0) ? w_invert : r_carry;
  assign w_nz_next = r_nz | (|w_sum);
  assign w_last    = (r_cnt == LAST_WORD);

  mp_word_adder #(
    .W (AW)
  ) u_adder (
    .iA   (r_a[AW-1:0]),
    .iB   (w_add_b),
    .iC   (w_cin),
    .oSum (w_sum),
    .oC   (w_cout)
  );

  // The result register doubles as the sum shift register: new words enter at the MSB.
  if (N_ITER > 1) begin : g_multi_word
    assign w_acc_next = {w_sum, r_res[OW-1:AW]};
  end else begin : g_single_word
    assign w_acc_next = w_sum;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_fin        = 1'b0;
    case (r_state)
      IDLE: begin
        if (iValid) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          if (r_op == OP_ABSDIFF && !r_second && !w_cout) begin
            w_next_state = SWAP;
          end else begin
            w_fin        = 1'b1;
            w_next_state = HOLD;
          end
        end
      end
      SWAP:    w_next_state = RUN;
      HOLD:    if (iReady) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_res_fin = '0;
    case (r_op)
      OP_ADD:     w_res_fin = {w_cout, w_acc_next};
      OP_SUB:     w_res_fin = {~w_cout, w_acc_next};
      OP_CMP:     w_res_fin = '0;
      OP_ABSDIFF: w_res_fin = {1'b0, w_acc_next};
      default:    w_res_fin = '0;
    endcase
    // A second pass only happens after a first-pass borrow, so A < B is already known.
    if (r_op == OP_ADD)  w_cmp_fin = CMP_NONE;
    else if (r_second)   w_cmp_fin = CMP_LT;
    else                 w_cmp_fin = cmp_code(~w_cout, w_nz_next);
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge iClk) begin
    // NOTE: the wide operand and shift registers are reset too, so no stale operand survives a reset.
    if (iRst) begin
      r_op     <= OP_ADD;
      r_sha    <= '0;
      r_shb    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_nz     <= 1'b0;
      r_second <= 1'b0;
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_cmp    <= CMP_NONE;
    end else begin
      if (w_accept) begin
        r_op     <= op_e'(iOp);
        r_sha    <= iOpA;
        r_shb    <= iOpB;
        r_a      <= iOpA;
        r_b      <= iOpB;
        r_cnt    <= '0;
        r_nz     <= 1'b0;
        r_second <= 1'b0;
      end
      if (r_state == RUN) begin
        r_a     <= r_a >> AW;
        r_b     <= r_b >> AW;
        r_carry <= w_cout;
        r_nz    <= w_nz_next;
        r_res   <= {r_res[OW], w_acc_next};
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == SWAP) begin
        r_a      <= r_shb;
        r_b      <= r_sha;
        r_cnt    <= '0;
        r_second <= 1'b1;
      end
      if (w_fin) begin
        r_valid <= 1'b1;
        r_res   <= w_res_fin;
        r_cmp   <= w_cmp_fin;
      end
      if (r_state == HOLD && iReady) r_valid <= 1'b0;
    end
  end

  assign oReady = (r_state == IDLE);
  assign oValid = r_valid;
  assign oRes   = r_res;
  assign oCmp   = r_cmp;

endmodule
